switch_allocator: RTL and testbench
===================================

Name: switch_allocator

Overview:
- Sequential controller that drives the select/reservation inputs of the router's mux crossbar: routeSelect, outputBusy and PortReserved.
- Each input port requests one output port. Every output runs its own round-robin arbiter and a hold-until-tail FSM.
- Sits between the per-input routing-computation stage and the crossbar, inside each mesh router (e.g. the 3x3 mesh routers).
- Guarantees one input per output, and at most one output per input.

Parameters:
- INPUTS, 5, number of crossbar input ports.
- OUTPUTS, 5, number of crossbar output ports.
- REQUEST_WIDTH, 32, width of each port-index field; matches the crossbar routeSelect field width.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-low reset.
- request_valid  input  INPUTS  input i requests an output; held high until granted.
- request_port  input  INPUTS*REQUEST_WIDTH  requested output index for input i.
- tail_in  input  INPUTS  the flit currently presented on input i is the packet tail.
- valid_in  input  INPUTS  crossbar-side valid of input i.
- ready_in  input  INPUTS  crossbar-side ready returned to input i.
- grant  output  INPUTS  1-cycle pulse: input i has just been granted its requested output.
- routeSelect  output  OUTPUTS*REQUEST_WIDTH  owning input index for output o.
- outputBusy  output  OUTPUTS  output o is allocated.
- PortReserved  output  INPUTS  input i owns some output.
- timeout_err  output  1  watchdog pulse; exists only with the optional feature.

Behaviour:
- All outputs are registered.
- Reset (rst=0 at a clk edge):
  - routeSelect=0, outputBusy=0, PortReserved=0, grant=0, timeout_err=0.
  - All owner registers and round-robin pointers are cleared to 0.
  - Reset asserted mid-packet drops every allocation immediately; no tail is needed.
- Per-output FSM with two states:
  - IDLE: outputBusy[o]=0.
  - BUSY: outputBusy[o]=1, routeSelect[o]=owner.
- IDLE->BUSY:
  - Eligible inputs for output o: request_valid[i]=1, request_port[i]==o, PortReserved[i]=0, and i not being granted another output this cycle.
  - If at least one input is eligible, pick the first eligible index at or above rr_ptr[o], wrapping modulo INPUTS.
  - Next cycle: owner=i, outputBusy[o]=1, PortReserved[i]=1, grant[i]=1 for exactly one cycle, rr_ptr[o]=(i+1) mod INPUTS.
  - Latency from request to grant is 1 cycle when the output is free.
- BUSY->IDLE:
  - Trigger: a tail handshake on the owner, i.e. valid_in[owner] & ready_in[owner] & tail_in[owner].
  - Next cycle: outputBusy[o]=0, PortReserved[owner]=0; routeSelect[o] keeps its old value.
  - The freed output is not re-granted in the same edge. It becomes arbitrable in the following cycle, so the minimum idle gap is 1 cycle.
- Because request_valid is held until granted, at most one output can ever match a given input's request_port. The one-grant-per-input rule therefore never conflicts.
- A request with request_port >= OUTPUTS is ignored: never granted, no state change.
- request_valid dropping before grant is legal: the request is withdrawn and rr_ptr is unchanged.
- An input whose PortReserved is already set is ignored as a requester until it is released.
- Non-tail handshakes have no effect on allocation.
- A tail handshake on an input that owns nothing is ignored.
- Simultaneous events:
  - Release on output A and grant on output B in the same cycle are independent.
  - One input may be released from A and, in the next arbitrable cycle, granted B.

Optional Feature:
- Macro: SWITCH_ALLOC_TIMEOUT_EN.
- Enabled:
  - Each output has a counter that clears on any valid_in & ready_in handshake of its owner and increments while BUSY.
  - When the count reaches TIMEOUT_CYCLES, the output is force-released exactly as for a tail (outputBusy=0, PortReserved[owner]=0 next cycle) and timeout_err pulses for 1 cycle.
  - The counter clears on reset and on release.
- Disabled: no counters; the timeout_err port is absent; allocation is held indefinitely until a tail handshake.

Test Plan:
- Single grant: reset, then request_valid[2]=1, request_port[2]=4 → next cycle grant[2]=1, outputBusy[4]=1, routeSelect[4]=2, PortReserved[2]=1.
- Round-robin: inputs 0, 1, 3 all request output 1 and each packet ends with a tail handshake → grants arrive in order 0, 1, 3, 0; outputBusy[1] is low for exactly 1 cycle between owners.
- Hold until tail: after granting input 0 to output 2, drive 3 non-tail handshakes then 1 tail handshake → outputBusy[2] stays 1 throughout and drops 1 cycle after the tail.
- Parallel / independent: input 0 requests output 3 and input 1 requests output 4 in the same cycle → both granted together; tail on input 0 releases only output 3.
- Boundary: request_port=5 with OUTPUTS=5 → no grant ever. Assert rst=0 while two outputs are BUSY → all outputs 0 next cycle.
- Timeout (SWITCH_ALLOC_TIMEOUT_EN, TIMEOUT_CYCLES=8): grant, then hold ready_in=0 → release and timeout_err=1 after 8 busy cycles without a handshake.

Source files
------------

// File: rtl/switch_allocator.sv
// Switch allocator for the mesh router crossbar.
// Each output has a round-robin arbiter and an IDLE/BUSY hold-until-tail FSM.
// It drives routeSelect, outputBusy and PortReserved, and pulses grant to the
// winning input. Every output is registered.
// Optional feature: define SWITCH_ALLOC_TIMEOUT_EN to add a per-output watchdog.
// When the owner makes no handshake for TIMEOUT_CYCLES busy cycles, the watchdog
// force-releases the output and pulses timeout_err.
module switch_allocator #(
  parameter int INPUTS         = 5,
  parameter int OUTPUTS        = 5,
  parameter int REQUEST_WIDTH  = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [INPUTS-1:0]                 request_valid,
  input  logic [INPUTS*REQUEST_WIDTH-1:0]   request_port,
  input  logic [INPUTS-1:0]                 tail_in,
  input  logic [INPUTS-1:0]                 valid_in,
  input  logic [INPUTS-1:0]                 ready_in,
  output logic [INPUTS-1:0]                 grant,
  output logic [OUTPUTS*REQUEST_WIDTH-1:0]  routeSelect,
  output logic [OUTPUTS-1:0]                outputBusy,
  output logic [INPUTS-1:0]                 PortReserved
`ifdef SWITCH_ALLOC_TIMEOUT_EN
  ,
  output logic                              timeout_err
`endif
);

  localparam int IDX_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e           state_q [OUTPUTS];
  state_e           state_d [OUTPUTS];
  logic [IDX_W-1:0] owner_q [OUTPUTS];
  logic [IDX_W-1:0] owner_d [OUTPUTS];
  logic [IDX_W-1:0] rr_q    [OUTPUTS];
  logic [IDX_W-1:0] rr_d    [OUTPUTS];
  logic [INPUTS-1:0] reserved_q, reserved_d;
  logic [INPUTS-1:0] grant_q, grant_d;

  int               sel;
  logic             found;
  logic [IDX_W-1:0] own;
  logic             hs;

`ifdef SWITCH_ALLOC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q [OUTPUTS];
  logic [CNT_W-1:0] cnt_d [OUTPUTS];
  logic             tmo_q, tmo_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // Per-output next state: release on tail (or watchdog) when BUSY, arbitrate when IDLE
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_d       = rr_q;
    reserved_d = reserved_q;
    grant_d    = '0;
    sel        = 0;
    found      = 1'b0;
    own        = '0;
    hs         = 1'b0;
`ifdef SWITCH_ALLOC_TIMEOUT_EN
    cnt_d      = cnt_q;
    tmo_d      = 1'b0;
`endif
    for (int o = 0; o < OUTPUTS; o++) begin
      if (state_q[o] == BUSY) begin
        own = owner_q[o];
        hs  = valid_in[own] & ready_in[own];
        if (hs && tail_in[own]) begin
          state_d[o]      = IDLE;
          reserved_d[own] = 1'b0;
`ifdef SWITCH_ALLOC_TIMEOUT_EN
          cnt_d[o]        = '0;
`endif
        end
`ifdef SWITCH_ALLOC_TIMEOUT_EN
        else if (hs) begin
          cnt_d[o] = '0;
        end else if (cnt_q[o] == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d[o]      = IDLE;
          reserved_d[own] = 1'b0;
          cnt_d[o]        = '0;
          tmo_d           = 1'b1;
        end else begin
          cnt_d[o] = cnt_q[o] + CNT_W'(1);
        end
`endif
      end else begin
        // An input released on this edge still has reserved_q set, so it
        // can only win again from the next cycle on.
        found = 1'b0;
        sel   = 0;
        for (int k = 0; k < INPUTS; k++) begin
          if (!found) begin
            sel = (int'(rr_q[o]) + k) % INPUTS;
            if (request_valid[sel] && !reserved_q[sel] &&
                request_port[sel*REQUEST_WIDTH +: REQUEST_WIDTH] == REQUEST_WIDTH'(o)) begin
              found = 1'b1;
            end
          end
        end
        if (found) begin
          state_d[o]      = BUSY;
          owner_d[o]      = IDX_W'(sel);
          rr_d[o]         = IDX_W'((sel + 1) % INPUTS);
          reserved_d[sel] = 1'b1;
          grant_d[sel]    = 1'b1;
        end
      end
    end
  end

  // State, owner, pointer and reservation registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int o = 0; o < OUTPUTS; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        rr_q[o]    <= '0;
`ifdef SWITCH_ALLOC_TIMEOUT_EN
        cnt_q[o]   <= '0;
`endif
      end
      reserved_q <= '0;
      grant_q    <= '0;
`ifdef SWITCH_ALLOC_TIMEOUT_EN
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      reserved_q <= reserved_d;
      grant_q    <= grant_d;
`ifdef SWITCH_ALLOC_TIMEOUT_EN
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  // Map registered state onto the crossbar-facing outputs
  always_comb begin
    routeSelect = '0;
    outputBusy  = '0;
    for (int o = 0; o < OUTPUTS; o++) begin
      routeSelect[o*REQUEST_WIDTH +: REQUEST_WIDTH] = REQUEST_WIDTH'(owner_q[o]);
      outputBusy[o] = (state_q[o] == BUSY);
    end
  end

  assign grant        = grant_q;
  assign PortReserved = reserved_q;
`ifdef SWITCH_ALLOC_TIMEOUT_EN
  assign timeout_err  = tmo_q;
`endif

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator with a cycle-level behavioural model.
module tb_switch_allocator;
  localparam int NI  = 5;
  localparam int NO  = 5;
  localparam int RW  = 32;
  localparam int TMO = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NI-1:0]     request_valid = '0;
  logic [NI*RW-1:0]  request_port  = '0;
  logic [NI-1:0]     tail_in  = '0;
  logic [NI-1:0]     valid_in = '0;
  logic [NI-1:0]     ready_in = '0;
  logic [NI-1:0]     grant;
  logic [NO*RW-1:0]  routeSelect;
  logic [NO-1:0]     outputBusy;
  logic [NI-1:0]     PortReserved;
  logic              timeout_err;

  switch_allocator #(
    .INPUTS(NI), .OUTPUTS(NO), .REQUEST_WIDTH(RW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .request_valid(request_valid), .request_port(request_port),
    .tail_in(tail_in), .valid_in(valid_in), .ready_in(ready_in),
    .grant(grant), .routeSelect(routeSelect),
    .outputBusy(outputBusy), .PortReserved(PortReserved)
`ifdef SWITCH_ALLOC_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

`ifndef SWITCH_ALLOC_TIMEOUT_EN
  assign timeout_err = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: owner per output (-1 = free), last route, rr pointer, reservations
  int m_owner [NO];
  int m_route [NO];
  int m_rr    [NO];
  int m_cnt   [NO];
  bit m_res   [NI];
  bit n_res   [NI];
  bit m_gnt   [NI];
  bit m_tmo;
  int w;
  bit mhs;

  always @(posedge clk) begin : model
    if (!rst) begin
      for (int o = 0; o < NO; o++) begin
        m_owner[o] = -1; m_route[o] = 0; m_rr[o] = 0; m_cnt[o] = 0;
      end
      for (int i = 0; i < NI; i++) begin m_res[i] = 0; m_gnt[i] = 0; end
      m_tmo = 0;
    end else begin
      n_res = m_res;
      for (int i = 0; i < NI; i++) m_gnt[i] = 0;
      m_tmo = 0;
      for (int o = 0; o < NO; o++) begin
        if (m_owner[o] >= 0) begin
          w   = m_owner[o];
          mhs = valid_in[w] && ready_in[w];
          if (mhs && tail_in[w]) begin
            m_owner[o] = -1; n_res[w] = 0; m_cnt[o] = 0;
          end
`ifdef SWITCH_ALLOC_TIMEOUT_EN
          else if (mhs) m_cnt[o] = 0;
          else begin
            m_cnt[o]++;
            if (m_cnt[o] == TMO) begin
              m_owner[o] = -1; n_res[w] = 0; m_cnt[o] = 0; m_tmo = 1;
            end
          end
`endif
        end else begin
          for (int k = 0; k < NI; k++) begin
            int i;
            i = (m_rr[o] + k) % NI;
            if (request_valid[i] && !m_res[i] && request_port[i*RW +: RW] == o) begin
              m_owner[o] = i; m_route[o] = i; n_res[i] = 1; m_gnt[i] = 1;
              m_rr[o] = (i + 1) % NI;
              break;
            end
          end
        end
      end
      m_res = n_res;
    end
  end

  logic [NI-1:0]    e_gnt, e_res;
  logic [NO-1:0]    e_busy;
  logic [NO*RW-1:0] e_route;

  // Compare every cycle once reset has been applied
  always @(negedge clk) begin : compare
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin e_gnt[i] = m_gnt[i]; e_res[i] = m_res[i]; end
      for (int o = 0; o < NO; o++) begin
        e_busy[o] = (m_owner[o] >= 0);
        e_route[o*RW +: RW] = m_route[o];
      end
      check("cyc_grant", grant, e_gnt);
      check("cyc_busy", outputBusy, e_busy);
      check("cyc_route", routeSelect, e_route);
      check("cyc_reserved", PortReserved, e_res);
`ifdef SWITCH_ALLOC_TIMEOUT_EN
      check("cyc_timeout", timeout_err, m_tmo);
`endif
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
    for (int i = 0; i < NI; i++) if (grant[i]) request_valid[i] = 1'b0;
  endtask

  task automatic set_port(input int i, input logic [RW-1:0] p);
    request_port[i*RW +: RW] = p;
  endtask

  function automatic logic [RW-1:0] route_of(input int o);
    return routeSelect[o*RW +: RW];
  endfunction

  logic [NI-1:0] gvec [8];
  logic [7:0]    bvec;
  logic [NI-1:0] acc;
  int            n;

  initial begin
    // Reset
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_busy", outputBusy, 0);
    check("rst_route", routeSelect, 0);
    check("rst_reserved", PortReserved, 0);
    check("rst_grant", grant, 0);
    rst = 1'b1;
    step();

    // Single grant: input 2 -> output 4
    set_port(2, 4); request_valid[2] = 1'b1;
    step();
    check("single_grant", grant, 5'b00100);
    check("single_busy", outputBusy, 5'b10000);
    check("single_route4", route_of(4), 2);
    check("single_reserved", PortReserved, 5'b00100);
    step();
    check("single_grant_pulse", grant, 0);
    valid_in[2] = 1; ready_in[2] = 1; tail_in[2] = 1;
    step();
    check("single_release_busy", outputBusy, 0);
    check("single_route_kept", route_of(4), 2);
    valid_in = '0; ready_in = '0; tail_in = '0;
    step();

    // Round-robin on output 1 with continuous tail handshakes
    set_port(0, 1); set_port(1, 1); set_port(3, 1);
    request_valid = 5'b01011;
    valid_in = 5'b01011; ready_in = 5'b01011; tail_in = 5'b01011;
    for (int s = 0; s < 8; s++) begin
      step();
      gvec[s] = grant;
      bvec[s] = outputBusy[1];
      if (s == 0) request_valid[0] = 1'b1;
    end
    valid_in = '0; ready_in = '0; tail_in = '0;
    check("rr_first", gvec[0], 5'b00001);
    check("rr_second", gvec[2], 5'b00010);
    check("rr_third", gvec[4], 5'b01000);
    check("rr_fourth", gvec[6], 5'b00001);
    check("rr_gap_grants", gvec[1] | gvec[3] | gvec[5] | gvec[7], 0);
    check("rr_busy_pattern", bvec, 8'b01010101);
    step();

    // Hold until tail: input 0 -> output 2
    set_port(0, 2); request_valid[0] = 1'b1;
    step();
    check("hold_grant", grant, 5'b00001);
    valid_in[0] = 1; ready_in[0] = 1; tail_in[0] = 0;
    for (int s = 0; s < 3; s++) begin
      step();
      check("hold_busy", outputBusy[2], 1'b1);
    end
    tail_in[0] = 1;
    step();
    check("hold_release", outputBusy[2], 1'b0);
    check("hold_reserved", PortReserved[0], 1'b0);
    valid_in = '0; ready_in = '0; tail_in = '0;
    step();

    // Parallel grants, then release on output 3 alongside a grant on output 0
    set_port(0, 3); set_port(1, 4); request_valid = 5'b00011;
    step();
    check("par_grant", grant, 5'b00011);
    check("par_busy", outputBusy, 5'b11000);
    check("par_route3", route_of(3), 0);
    check("par_route4", route_of(4), 1);
    valid_in[0] = 1; ready_in[0] = 1; tail_in[0] = 1;
    set_port(2, 0); request_valid[2] = 1'b1;
    step();
    check("par_release_busy", outputBusy, 5'b10001);
    check("par_release_res", PortReserved, 5'b00110);
    check("par_release_grant", grant, 5'b00100);
    valid_in = '0; ready_in = '0; tail_in = '0;

    // Out-of-range requests are never granted
    set_port(3, 5); set_port(4, 32'hFFFF_FFFF);
    request_valid[3] = 1'b1; request_valid[4] = 1'b1;
    acc = '0;
    for (int s = 0; s < 4; s++) begin
      step();
      acc |= grant;
    end
    check("oob_no_grant", acc, 0);
    check("oob_reserved", PortReserved, 5'b00110);
    request_valid = '0;

    // Reset while outputs 0 and 4 are busy
    rst = 1'b0;
    step();
    check("midrst_busy", outputBusy, 0);
    check("midrst_reserved", PortReserved, 0);
    check("midrst_route", routeSelect, 0);
    rst = 1'b1;
    step();

    // Pointers cleared: inputs 1 and 3 contend for output 4, input 1 wins
    set_port(1, 4); set_port(3, 4); request_valid = 5'b01010;
    step();
    check("post_rst_rr", grant, 5'b00010);

`ifdef SWITCH_ALLOC_TIMEOUT_EN
    // Watchdog: owner 1 never handshakes
    n = 0;
    while (outputBusy[4] && !timeout_err && n < 20) begin
      step();
      n++;
    end
    check("tmo_cycles", n, 8);
    check("tmo_pulse", timeout_err, 1'b1);
    check("tmo_reserved", PortReserved[1], 1'b0);
`else
    n = 0;
`endif
    request_valid = '0;
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
